// File: rtl/pl_regbank.sv
// pl_regbank: AXI4-Lite slave with NUM_RW control and NUM_RO status
// words, byte-strobe writes, and a one-cycle write pulse per control reg.
// Ports: S_AXI_* AXI4-Lite slave (sync active-high S_AXI_ARESET),
//   ctrl_o control contents (reg k at [k*DATA_WIDTH +: DATA_WIDTH]),
//   wr_pulse_o one-cycle pulse per written control reg,
//   status_i fabric status words read back at NUM_RW and above.
// Option: define PL_REGBANK_SLVERR_EN to answer illegal accesses with
//   SLVERR; otherwise every response is OKAY.
module pl_regbank #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int NUM_RW     = 4,
   parameter int NUM_RO     = 4
) (
   input  logic                         S_AXI_ACLK,
   input  logic                         S_AXI_ARESET,
   input  logic [ADDR_WIDTH-1:0]        S_AXI_AWADDR,
   input  logic [2:0]                   S_AXI_AWPROT,
   input  logic                         S_AXI_AWVALID,
   output logic                         S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]        S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
   input  logic                         S_AXI_WVALID,
   output logic                         S_AXI_WREADY,
   output logic [1:0]                   S_AXI_BRESP,
   output logic                         S_AXI_BVALID,
   input  logic                         S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]        S_AXI_ARADDR,
   input  logic [2:0]                   S_AXI_ARPROT,
   input  logic                         S_AXI_ARVALID,
   output logic                         S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]        S_AXI_RDATA,
   output logic [1:0]                   S_AXI_RRESP,
   output logic                         S_AXI_RVALID,
   input  logic                         S_AXI_RREADY,
   output logic [NUM_RW*DATA_WIDTH-1:0] ctrl_o,
   output logic [NUM_RW-1:0]            wr_pulse_o,
   input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_WIDTH-1:0] status_i
);

   localparam int NB       = DATA_WIDTH / 8;
   localparam int ADDR_LSB = $clog2(NB);
   localparam int NREG     = NUM_RW + NUM_RO;
   localparam int IDX_W    = (NREG > 1) ? $clog2(NREG) : 1;

   localparam logic [1:0] RESP_OK  = 2'b00;
`ifdef PL_REGBANK_SLVERR_EN
   localparam logic [1:0] RESP_ERR = 2'b10;
`else
   localparam logic [1:0] RESP_ERR = 2'b00;
`endif

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t w_st;
   r_state_t r_st;

   logic [NUM_RW-1:0][DATA_WIDTH-1:0] ctrl_q;
   logic [1:0]            bresp_q;
   logic [1:0]            rresp_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] rd_nxt;
   logic [NUM_RW-1:0]     pulse_q;

   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   logic             wr_ok;
   logic             rd_ok;
   logic             wr_hs;
   logic             rd_hs;

   logic unused_prot;
   assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

   // Legal when nothing sits above the index field and index < lim.
   function automatic logic addr_ok(
      input logic [ADDR_WIDTH-1:0] a,
      input int                    lim
   );
      logic [ADDR_WIDTH-1:0] hi;
      hi = a >> (ADDR_LSB + IDX_W);
      return (hi == '0) && (int'(a[ADDR_LSB +: IDX_W]) < lim);
   endfunction

   assign wr_idx = S_AXI_AWADDR[ADDR_LSB +: IDX_W];
   assign rd_idx = S_AXI_ARADDR[ADDR_LSB +: IDX_W];
   assign wr_ok  = addr_ok(S_AXI_AWADDR, NUM_RW);
   assign rd_ok  = addr_ok(S_AXI_ARADDR, NREG);

   // Address and data are only taken together, never one alone.
   assign wr_hs = ~S_AXI_ARESET & (w_st == W_IDLE)
                & S_AXI_AWVALID & S_AXI_WVALID;
   assign rd_hs = ~S_AXI_ARESET & (r_st == R_IDLE)
                & S_AXI_ARVALID;

   assign S_AXI_AWREADY = wr_hs;
   assign S_AXI_WREADY  = wr_hs;
   assign S_AXI_ARREADY = rd_hs;
   assign S_AXI_BVALID  = (w_st == W_RESP);
   assign S_AXI_RVALID  = (r_st == R_DATA);
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_RRESP   = rresp_q;
   assign S_AXI_RDATA   = rdata_q;
   assign ctrl_o        = ctrl_q;
   assign wr_pulse_o    = pulse_q;

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         w_st    <= W_IDLE;
         bresp_q <= RESP_OK;
         ctrl_q  <= '0;
         pulse_q <= '0;
      end else begin
         pulse_q <= '0;
         unique case (w_st)
            W_IDLE: begin
               if (wr_hs) begin
                  w_st    <= W_RESP;
                  bresp_q <= wr_ok ? RESP_OK : RESP_ERR;
                  for (int k = 0; k < NUM_RW; k++) begin
                     if (wr_ok && int'(wr_idx) == k) begin
                        pulse_q[k] <= 1'b1;
                        for (int b = 0; b < NB; b++) begin
                           if (S_AXI_WSTRB[b])
                              ctrl_q[k][b*8 +: 8] <=
                                 S_AXI_WDATA[b*8 +: 8];
                        end
                     end
                  end
               end
            end
            W_RESP: begin
               if (S_AXI_BREADY)
                  w_st <= W_IDLE;
            end
            default: w_st <= W_IDLE;
         endcase
      end
   end

   // Sees ctrl_q before any same-edge write lands.
   always_comb begin
      rd_nxt = '0;
      if (rd_ok) begin
         for (int k = 0; k < NUM_RW; k++) begin
            if (int'(rd_idx) == k)
               rd_nxt = ctrl_q[k];
         end
         for (int j = 0; j < NUM_RO; j++) begin
            if (int'(rd_idx) == NUM_RW + j)
               rd_nxt = status_i[j*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         r_st    <= R_IDLE;
         rdata_q <= '0;
         rresp_q <= RESP_OK;
      end else begin
         unique case (r_st)
            R_IDLE: begin
               if (rd_hs) begin
                  r_st    <= R_DATA;
                  rdata_q <= rd_nxt;
                  rresp_q <= rd_ok ? RESP_OK : RESP_ERR;
               end
            end
            R_DATA: begin
               if (S_AXI_RREADY)
                  r_st <= R_IDLE;
            end
            default: r_st <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pl_regbank.sv
// tb_pl_regbank: directed and random AXI4-Lite traffic for pl_regbank,
// checked against an array model of the register map.
module tb_pl_regbank;

   logic         clk = 1'b0;
   logic         areset;
   logic [7:0]   awaddr;
   logic [2:0]   awprot;
   logic         awvalid;
   logic         awready;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic         wvalid;
   logic         wready;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready;
   logic [7:0]   araddr;
   logic [2:0]   arprot;
   logic         arvalid;
   logic         arready;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rvalid;
   logic         rready;
   logic [127:0] ctrl_o;
   logic [3:0]   pulse;
   logic [127:0] status_i;

`ifdef PL_REGBANK_SLVERR_EN
   localparam logic [1:0] ERR = 2'b10;
`else
   localparam logic [1:0] ERR = 2'b00;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] ctrl_m [4];
   logic [31:0] stat_m [4];

   always #5 clk = ~clk;

   pl_regbank dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESET  (areset),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .ctrl_o        (ctrl_o),
      .wr_pulse_o    (pulse),
      .status_i      (status_i)
   );

   task automatic chk(
      input string        tag,
      input logic [127:0] obs,
      input logic [127:0] exp
   );
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] ctrl_flat();
      logic [127:0] r;
      for (int k = 0; k < 4; k++)
         r[k*32 +: 32] = ctrl_m[k];
      return r;
   endfunction

   task automatic set_status();
      for (int j = 0; j < 4; j++) begin
         stat_m[j] = $urandom;
         status_i[j*32 +: 32] = stat_m[j];
      end
   endtask

   task automatic model_write(
      input logic [7:0]  a,
      input logic [31:0] d,
      input logic [3:0]  s
   );
      int w;
      w = int'(a) / 4;
      if (w < 4)
         for (int b = 0; b < 4; b++)
            if (s[b]) ctrl_m[w][b*8 +: 8] = d[b*8 +: 8];
   endtask

   task automatic do_write(
      input logic [7:0]  a,
      input logic [31:0] d,
      input logic [3:0]  s
   );
      int w;
      int n;
      logic [3:0] ep;
      logic [1:0] er;
      w  = int'(a) / 4;
      ep = (w < 4) ? 4'(1 << w) : 4'h0;
      er = (w < 4) ? 2'b00 : ERR;
      @(negedge clk);
      awaddr  = a;
      awprot  = 3'($urandom);
      wdata   = d;
      wstrb   = s;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      bready  = 1'b0;
      #1;
      n = 0;
      while (!(awready && wready) && n < 16) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("aw_w_accept", {awready, wready}, 2'b11);
      model_write(a, d, s);
      @(negedge clk);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      #1;
      chk("bvalid", bvalid, 1'b1);
      chk("bresp", bresp, er);
      chk("wr_pulse", pulse, ep);
      chk("ctrl_o", ctrl_o, ctrl_flat());
      bready = 1'b1;
      @(negedge clk);
      #1;
      chk("bvalid_clr", bvalid, 1'b0);
      chk("pulse_clr", pulse, 4'h0);
      bready = 1'b0;
   endtask

   task automatic do_read(
      input  logic [7:0]  a,
      output logic [31:0] got
   );
      int w;
      int n;
      logic [31:0] ed;
      logic [1:0]  er;
      w = int'(a) / 4;
      if (w < 4)      ed = ctrl_m[w];
      else if (w < 8) ed = stat_m[w-4];
      else            ed = 32'h0;
      er = (w < 8) ? 2'b00 : ERR;
      @(negedge clk);
      araddr  = a;
      arprot  = 3'($urandom);
      arvalid = 1'b1;
      rready  = 1'b0;
      #1;
      n = 0;
      while (!arready && n < 16) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("ar_accept", arready, 1'b1);
      @(negedge clk);
      arvalid = 1'b0;
      set_status();
      #1;
      chk("rvalid", rvalid, 1'b1);
      chk("rdata", rdata, ed);
      chk("rresp", rresp, er);
      got = rdata;
      rready = 1'b1;
      @(negedge clk);
      #1;
      chk("rvalid_clr", rvalid, 1'b0);
      rready = 1'b0;
   endtask

   initial begin
      logic [31:0] got;
      logic [1:0]  br;
      logic [31:0] old;

      areset   = 1'b1;
      awaddr   = '0;
      awprot   = '0;
      wdata    = '0;
      wstrb    = '0;
      araddr   = '0;
      arprot   = '0;
      awvalid  = 1'b1;
      wvalid   = 1'b1;
      arvalid  = 1'b1;
      bready   = 1'b0;
      rready   = 1'b0;
      status_i = '0;
      for (int k = 0; k < 4; k++) ctrl_m[k] = '0;
      set_status();

      // No acceptance while reset is held.
      repeat (2) @(negedge clk);
      #1;
      chk("rst_awready", awready, 1'b0);
      chk("rst_arready", arready, 1'b0);
      @(negedge clk);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      arvalid = 1'b0;
      areset  = 1'b0;
      #1;
      chk("rst_bvalid", bvalid, 1'b0);
      chk("rst_rvalid", rvalid, 1'b0);
      chk("rst_bresp", bresp, 2'b00);
      chk("rst_rresp", rresp, 2'b00);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_ctrl", ctrl_o, 128'h0);
      chk("rst_pulse", pulse, 4'h0);

      // Basic write/read-back of all control regs.
      for (int k = 0; k < 4; k++)
         do_write(8'(4 * k), 32'(k + 1), 4'hF);
      for (int k = 0; k < 4; k++) begin
         do_read(8'(4 * k), got);
         chk("readback", got, 32'(k + 1));
      end

      // Byte strobes.
      do_write(8'h00, 32'hAABBCCDD, 4'hF);
      do_write(8'h00, 32'h11223344, 4'b0101);
      do_read(8'h00, got);
      chk("strobe_merge", got, 32'hAA22CC44);

      // Zero strobe still pulses, changes nothing.
      do_write(8'h04, 32'hFFFFFFFF, 4'h0);

      // Status read and illegal status write.
      stat_m[0] = 32'hDEADBEEF;
      status_i[31:0] = stat_m[0];
      do_read(8'h10, got);
      chk("status0", got, 32'hDEADBEEF);
      do_write(8'h10, 32'h5, 4'hF);

      // Out of range read and write.
      do_read(8'h40, got);
      chk("oor_rdata", got, 32'h0);
      do_write(8'h40, 32'h12345678, 4'hF);
      do_write(8'h23, 32'h12345678, 4'hF);

      // Write response held off for 10 cycles.
      @(negedge clk);
      awaddr  = 8'h08;
      wdata   = 32'hCAFE0008;
      wstrb   = 4'hF;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      #1;
      chk("stall_aw_acc", awready, 1'b1);
      model_write(8'h08, 32'hCAFE0008, 4'hF);
      @(negedge clk);
      awaddr = 8'h04;
      wdata  = 32'h0BAD0BAD;
      #1;
      br = bresp;
      for (int i = 0; i < 10; i++) begin
         chk("stall_bvalid", bvalid, 1'b1);
         chk("stall_bresp", bresp, br);
         chk("stall_awready", awready, 1'b0);
         @(negedge clk);
         #1;
      end
      chk("stall_ctrl", ctrl_o, ctrl_flat());
      awvalid = 1'b0;
      wvalid  = 1'b0;
      bready  = 1'b1;
      @(negedge clk);
      #1;
      chk("stall_bclr", bvalid, 1'b0);
      bready = 1'b0;

      // Read data held off for 10 cycles.
      @(negedge clk);
      araddr  = 8'h14;
      arvalid = 1'b1;
      #1;
      chk("stall_ar_acc", arready, 1'b1);
      old = stat_m[1];
      @(negedge clk);
      araddr = 8'h00;
      #1;
      for (int i = 0; i < 10; i++) begin
         set_status();
         chk("stall_rvalid", rvalid, 1'b1);
         chk("stall_rdata", rdata, old);
         chk("stall_arready", arready, 1'b0);
         @(negedge clk);
         #1;
      end
      arvalid = 1'b0;
      rready  = 1'b1;
      @(negedge clk);
      #1;
      chk("stall_rclr", rvalid, 1'b0);
      rready = 1'b0;

      // Same-edge read and write of reg 0.
      @(negedge clk);
      old     = ctrl_m[0];
      awaddr  = 8'h00;
      wdata   = 32'h5A5A5A5A;
      wstrb   = 4'hF;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      araddr  = 8'h00;
      arvalid = 1'b1;
      #1;
      chk("dual_accept", {awready, arready}, 2'b11);
      model_write(8'h00, 32'h5A5A5A5A, 4'hF);
      @(negedge clk);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      arvalid = 1'b0;
      #1;
      chk("dual_rdata", rdata, old);
      chk("dual_ctrl", ctrl_o, ctrl_flat());
      bready = 1'b1;
      rready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      rready = 1'b0;

      // Reset while a write response is pending.
      @(negedge clk);
      awaddr  = 8'h0C;
      wdata   = 32'h77777777;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      #1;
      chk("pre_rst_bvalid", bvalid, 1'b1);
      areset = 1'b1;
      @(negedge clk);
      areset = 1'b0;
      #1;
      chk("mid_rst_bvalid", bvalid, 1'b0);
      chk("mid_rst_ctrl", ctrl_o, 128'h0);
      chk("mid_rst_pulse", pulse, 4'h0);
      for (int k = 0; k < 4; k++) ctrl_m[k] = '0;
      do_write(8'h0C, 32'h13579BDF, 4'hF);
      do_read(8'h0C, got);
      chk("post_rst_read", got, 32'h13579BDF);

      // Random traffic against the model.
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 1) == 0)
            do_write(8'($urandom_range(0, 63)),
                     $urandom, 4'($urandom));
         else
            do_read(8'($urandom_range(0, 63)), got);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
